// File: rtl/quic_pkg.sv
// quic_pkg: shared frame type constants, error codes, parser states and the varint length helper
package quic_pkg;
  localparam logic [7:0] FT_PADDING = 8'h00;
  localparam logic [7:0] FT_PING = 8'h01;
  localparam logic [7:0] FT_ACK = 8'h02;
  localparam logic [7:0] FT_CRYPTO = 8'h06;
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_UNSUPPORTED,
    ERR_TRUNCATED,
    ERR_ENCODING
  } err_code_e;
  typedef enum logic [3:0] {
    S_TYPE,
    S_ACK_LARGEST,
    S_ACK_DELAY,
    S_ACK_RCOUNT,
    S_ACK_FIRST,
    S_ACK_GAP,
    S_ACK_LEN,
    S_CRYPTO_OFF,
    S_CRYPTO_LEN,
    S_CRYPTO_DATA,
    S_DRAIN
  } state_e;
  function automatic logic [3:0] varint_len(input logic [1:0] prefix);
    return 4'd1 << prefix;
  endfunction
endpackage

// File: rtl/quic_varint_rx.sv
// quic_varint_rx: byte-serial varint accumulator; start/byte_valid/byte_data in, done/value out combinationally on the final byte
module quic_varint_rx import quic_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        done,
  output logic [61:0] value
);
  logic [2:0] rem;
  logic [53:0] acc;
  logic [3:0] len;
  logic first;
  assign first = start || rem == 3'd0;
  assign len = varint_len(byte_data[7:6]);
  assign done = byte_valid && (first ? len == 4'd1 : rem == 3'd1);
  assign value = first ? {56'd0, byte_data[5:0]} : {acc, byte_data};
  always_ff @(posedge clk) begin
    if (rst) begin
      rem <= '0;
      acc <= '0;
    end else if (byte_valid) begin
      rem <= first ? 3'(len - 4'd1) : rem - 3'd1;
      acc <= first ? {48'd0, byte_data[5:0]} : {acc[45:0], byte_data};
    end
  end
endmodule

// File: rtl/quic_frame_parser.sv
// quic_frame_parser: byte-serial QUIC payload frame splitter; in_valid/in_data/in_last in, CRYPTO bytes, ACK fields, err and per-packet status out
module quic_frame_parser import quic_pkg::*; #(
  parameter int MAX_ACK_RANGES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        crypto_valid,
  output logic [7:0]  crypto_data,
  output logic [61:0] crypto_offset,
  output logic        crypto_last,
  output logic        ack_valid,
  output logic [61:0] ack_largest,
  output logic [61:0] ack_delay,
  output logic [61:0] ack_first_range,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        pkt_done,
  output logic        pkt_err,
  output logic        ack_eliciting
);
  localparam int RW = $clog2(MAX_ACK_RANGES + 1);
  state_e st, nxt;
  err_code_e code;
  logic v_start, v_done, ack_done, c_ovf, err_now, elic, emit, sop, pe, ae;
  logic [61:0] v_val, c_off, c_rem, a_l, a_d, a_f;
  logic [62:0] c_sum;
  logic [RW-1:0] rl;
  // Bytes outside varint fields restart the accumulator, so every field begins clean.
  assign v_start = st == S_TYPE || st == S_CRYPTO_DATA || st == S_DRAIN;
  assign c_sum = {1'b0, c_off} + {1'b0, v_val};
  assign c_ovf = c_sum[62] && |c_sum[61:0];
  quic_varint_rx u_varint (
    .clk(clk),
    .rst(rst),
    .start(v_start),
    .byte_valid(in_valid),
    .byte_data(in_data),
    .done(v_done),
    .value(v_val)
  );
  always_ff @(posedge clk) begin
    if (rst) st <= S_TYPE;
    else st <= nxt;
  end
  always_comb begin
    nxt = st;
    code = ERR_NONE;
    ack_done = 1'b0;
    if (in_valid) begin
      case (st)
        S_TYPE: begin
          nxt = (in_data == FT_PADDING || in_data == FT_PING) ? S_TYPE :
                in_data == FT_ACK ? S_ACK_LARGEST :
                in_data == FT_CRYPTO ? S_CRYPTO_OFF : S_DRAIN;
          code = nxt == S_DRAIN ? ERR_UNSUPPORTED : ERR_NONE;
        end
        S_ACK_LARGEST: nxt = v_done ? S_ACK_DELAY : st;
        S_ACK_DELAY: nxt = v_done ? S_ACK_RCOUNT : st;
        S_ACK_RCOUNT: if (v_done) begin
          nxt = v_val > 62'(MAX_ACK_RANGES) ? S_DRAIN : S_ACK_FIRST;
          code = nxt == S_DRAIN ? ERR_ENCODING : ERR_NONE;
        end
        S_ACK_FIRST: if (v_done) begin
          ack_done = rl == '0;
          nxt = ack_done ? S_TYPE : S_ACK_GAP;
        end
        S_ACK_GAP: nxt = v_done ? S_ACK_LEN : st;
        S_ACK_LEN: if (v_done) begin
          ack_done = rl == RW'(1);
          nxt = ack_done ? S_TYPE : S_ACK_GAP;
        end
        S_CRYPTO_OFF: nxt = v_done ? S_CRYPTO_LEN : st;
        S_CRYPTO_LEN: if (v_done) begin
          nxt = c_ovf ? S_DRAIN : v_val == '0 ? S_TYPE : S_CRYPTO_DATA;
          code = c_ovf ? ERR_ENCODING : ERR_NONE;
        end
        S_CRYPTO_DATA: nxt = c_rem == 62'd1 ? S_TYPE : st;
        default: nxt = S_DRAIN;
      endcase
      // A packet may only end on a frame boundary; DRAIN already carries its error.
      if (in_last && code == ERR_NONE && st != S_DRAIN && nxt != S_TYPE) code = ERR_TRUNCATED;
      if (in_last) nxt = S_TYPE;
    end
  end
  always_comb begin
    err_now = code != ERR_NONE;
    elic = in_valid && st == S_TYPE && in_data != FT_PADDING && in_data != FT_ACK;
    emit = in_valid && st == S_CRYPTO_DATA;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      crypto_valid <= 1'b0;
      crypto_data <= '0;
      crypto_offset <= '0;
      crypto_last <= 1'b0;
      ack_valid <= 1'b0;
      ack_largest <= '0;
      ack_delay <= '0;
      ack_first_range <= '0;
      err <= 1'b0;
      err_code <= '0;
      pkt_done <= 1'b0;
      pkt_err <= 1'b0;
      ack_eliciting <= 1'b0;
      sop <= 1'b1;
      pe <= 1'b0;
      ae <= 1'b0;
      c_off <= '0;
      c_rem <= '0;
      a_l <= '0;
      a_d <= '0;
      a_f <= '0;
      rl <= '0;
    end else begin
      crypto_valid <= emit;
      crypto_last <= emit && c_rem == 62'd1;
      ack_valid <= ack_done;
      err <= err_now;
      pkt_done <= in_valid && in_last;
      pkt_err <= in_valid && in_last && (pe || err_now);
      ack_eliciting <= in_valid && in_last && (ae || elic);
      if (in_valid) begin
        sop <= in_last;
        pe <= !in_last && (pe || err_now);
        ae <= !in_last && (ae || elic);
        err_code <= err_now ? code : sop ? 2'd0 : err_code;
      end
      if (emit) begin
        crypto_data <= in_data;
        crypto_offset <= c_off;
        c_off <= c_off + 62'd1;
        c_rem <= c_rem - 62'd1;
      end
      if (v_done) begin
        case (st)
          S_CRYPTO_OFF: c_off <= v_val;
          S_CRYPTO_LEN: c_rem <= v_val;
          S_ACK_LARGEST: a_l <= v_val;
          S_ACK_DELAY: a_d <= v_val;
          S_ACK_RCOUNT: rl <= v_val[RW-1:0];
          S_ACK_FIRST: a_f <= v_val;
          S_ACK_LEN: rl <= rl - RW'(1);
          default: ;
        endcase
      end
      if (ack_done) begin
        ack_largest <= a_l;
        ack_delay <= a_d;
        ack_first_range <= st == S_ACK_FIRST ? v_val : a_f;
      end
    end
  end
endmodule

// File: tb/tb_quic_frame_parser.sv
// tb_quic_frame_parser: directed self-checking bench for quic_frame_parser
module tb_quic_frame_parser;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic in_last = 1'b0;
  logic crypto_valid, crypto_last, ack_valid, err, pkt_done, pkt_err, ack_eliciting;
  logic [7:0] crypto_data;
  logic [61:0] crypto_offset, ack_largest, ack_delay, ack_first_range;
  logic [1:0] err_code;
  int nvec = 0;
  int nerr = 0;
  quic_frame_parser dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .crypto_valid(crypto_valid),
    .crypto_data(crypto_data),
    .crypto_offset(crypto_offset),
    .crypto_last(crypto_last),
    .ack_valid(ack_valid),
    .ack_largest(ack_largest),
    .ack_delay(ack_delay),
    .ack_first_range(ack_first_range),
    .err(err),
    .err_code(err_code),
    .pkt_done(pkt_done),
    .pkt_err(pkt_err),
    .ack_eliciting(ack_eliciting)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic put(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data = d;
    in_last = l;
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
  endtask
  task automatic chk_c(input string tag, input logic v, input logic [7:0] d, input logic [61:0] o, input logic l);
    chk({tag, ".valid"}, 64'(crypto_valid), 64'(v));
    chk({tag, ".data"}, 64'(crypto_data), 64'(d));
    chk({tag, ".offset"}, 64'(crypto_offset), 64'(o));
    chk({tag, ".last"}, 64'(crypto_last), 64'(l));
  endtask
  task automatic chk_p(input string tag, input logic d, input logic e, input logic a);
    chk({tag, ".pkt_done"}, 64'(pkt_done), 64'(d));
    chk({tag, ".pkt_err"}, 64'(pkt_err), 64'(e));
    chk({tag, ".ack_eliciting"}, 64'(ack_eliciting), 64'(a));
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_c("reset", 0, 8'h00, 62'd0, 0);
    chk("reset.ack_valid", 64'(ack_valid), 0);
    chk("reset.ack_largest", 64'(ack_largest), 0);
    chk("reset.err", 64'(err), 0);
    chk("reset.err_code", 64'(err_code), 0);
    chk_p("reset", 0, 0, 0);
    rst = 1'b0;
    put(8'h01, 0);
    chk("ping.crypto_valid", 64'(crypto_valid), 0);
    chk("ping.ack_valid", 64'(ack_valid), 0);
    chk("ping.pkt_done", 64'(pkt_done), 0);
    put(8'h00, 0);
    put(8'h00, 1);
    chk_p("ping.end", 1, 0, 1);
    chk("ping.err", 64'(err), 0);
    idle();
    chk("ping.done_pulse", 64'(pkt_done), 0);
    put(8'h06, 0);
    put(8'h00, 0);
    put(8'h03, 0);
    chk("crypto.no_data_yet", 64'(crypto_valid), 0);
    put(8'hAA, 0);
    chk_c("crypto.b0", 1, 8'hAA, 62'd0, 0);
    put(8'hBB, 0);
    chk_c("crypto.b1", 1, 8'hBB, 62'd1, 0);
    put(8'hCC, 1);
    chk_c("crypto.b2", 1, 8'hCC, 62'd2, 1);
    chk_p("crypto.end", 1, 0, 1);
    put(8'h06, 0);
    put(8'h41, 0);
    idle();
    chk("gap.idle0", 64'(crypto_valid), 0);
    idle();
    put(8'h00, 0);
    put(8'h02, 0);
    put(8'h11, 0);
    chk_c("vint2.b0", 1, 8'h11, 62'h100, 0);
    put(8'h22, 1);
    chk_c("vint2.b1", 1, 8'h22, 62'h101, 1);
    chk_p("vint2.end", 1, 0, 1);
    put(8'h02, 0);
    put(8'h0A, 0);
    put(8'h00, 0);
    put(8'h00, 0);
    chk("ack.early", 64'(ack_valid), 0);
    put(8'h03, 0);
    chk("ack.valid", 64'(ack_valid), 1);
    chk("ack.largest", 64'(ack_largest), 10);
    chk("ack.delay", 64'(ack_delay), 0);
    chk("ack.first", 64'(ack_first_range), 3);
    put(8'h00, 1);
    chk("ack.pulse", 64'(ack_valid), 0);
    chk("ack.held", 64'(ack_largest), 10);
    chk_p("ack.end", 1, 0, 0);
    put(8'h10, 0);
    chk("unsup.err", 64'(err), 1);
    chk("unsup.code", 64'(err_code), 1);
    chk("unsup.done", 64'(pkt_done), 0);
    put(8'h11, 0);
    chk("unsup.err_pulse", 64'(err), 0);
    chk("unsup.code_held", 64'(err_code), 1);
    put(8'h12, 1);
    chk_p("unsup.end", 1, 1, 1);
    chk("unsup.no_err", 64'(err), 0);
    put(8'h06, 0);
    chk("trunc.code_clr", 64'(err_code), 0);
    put(8'h00, 0);
    put(8'h05, 0);
    put(8'hAA, 1);
    chk("trunc.err", 64'(err), 1);
    chk("trunc.code", 64'(err_code), 2);
    chk("trunc.done", 64'(pkt_done), 1);
    chk("trunc.pkt_err", 64'(pkt_err), 1);
    put(8'h02, 0);
    put(8'h05, 0);
    put(8'h01, 0);
    put(8'h01, 0);
    put(8'h02, 0);
    chk("ack1.not_yet", 64'(ack_valid), 0);
    put(8'h00, 0);
    put(8'h01, 1);
    chk("ack1.valid", 64'(ack_valid), 1);
    chk("ack1.largest", 64'(ack_largest), 5);
    chk("ack1.delay", 64'(ack_delay), 1);
    chk("ack1.first", 64'(ack_first_range), 2);
    chk_p("ack1.end", 1, 0, 0);
    put(8'h02, 0);
    put(8'h00, 0);
    put(8'h00, 0);
    put(8'h09, 0);
    chk("rc9.err", 64'(err), 1);
    chk("rc9.code", 64'(err_code), 3);
    put(8'h00, 1);
    chk_p("rc9.end", 1, 1, 0);
    chk("rc9.no_ack", 64'(ack_valid), 0);
    put(8'h02, 0);
    put(8'h00, 0);
    put(8'h00, 0);
    put(8'h08, 0);
    chk("rc8.no_err", 64'(err), 0);
    put(8'h00, 1);
    chk("rc8.trunc_err", 64'(err), 1);
    chk("rc8.trunc_code", 64'(err_code), 2);
    chk("rc8.no_ack", 64'(ack_valid), 0);
    put(8'h06, 0);
    put(8'h00, 0);
    put(8'h00, 0);
    chk("len0.no_data", 64'(crypto_valid), 0);
    chk("len0.no_err", 64'(err), 0);
    put(8'h01, 1);
    chk("len0.no_data2", 64'(crypto_valid), 0);
    chk_p("len0.end", 1, 0, 1);
    put(8'h06, 0);
    for (int i = 0; i < 8; i++) put(8'hFF, 0);
    put(8'h01, 0);
    chk("maxoff.no_err", 64'(err), 0);
    put(8'h5A, 1);
    chk_c("maxoff.b0", 1, 8'h5A, 62'h3FFF_FFFF_FFFF_FFFF, 1);
    chk_p("maxoff.end", 1, 0, 1);
    put(8'h06, 0);
    for (int i = 0; i < 8; i++) put(8'hFF, 0);
    put(8'h02, 0);
    chk("ovf.err", 64'(err), 1);
    chk("ovf.code", 64'(err_code), 3);
    put(8'hAA, 1);
    chk("ovf.drain_no_data", 64'(crypto_valid), 0);
    chk_p("ovf.end", 1, 1, 1);
    put(8'h06, 0);
    put(8'h00, 0);
    put(8'h04, 0);
    put(8'hAA, 0);
    chk_c("rstmid.b0", 1, 8'hAA, 62'd0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_c("rstmid.clr", 0, 8'h00, 62'd0, 0);
    chk_p("rstmid.clr", 0, 0, 0);
    idle();
    chk("rstmid.no_done", 64'(pkt_done), 0);
    put(8'h01, 1);
    chk_p("after_rst", 1, 0, 1);
    chk("after_rst.err", 64'(err), 0);
    chk("after_rst.code", 64'(err_code), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
